// File: rtl/fetch_stage.sv
// fetch_stage -- instruction-fetch stage of the 5-stage WISC pipeline.
//
// Owns the PC and issues one request at a time to instruction memory over a
// request/done handshake. Fetched instructions are handed to decode through
// an IF/ID output register. The stage honours decode back-pressure, flushes
// and refetches on a branch/jump redirect, and stops fetching after a HALT.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   stall             decode cannot accept; IF/ID register holds
//   redirect          flush and refetch from redirectPc (wins over all else)
//   redirectPc        redirect target
//   imemEn/imemAddr   one-cycle memory request strobe and address
//   imemData          returned instruction, valid with imemDone
//   imemDone/imemErr  memory response strobe and error flag
//   instrOut          IF/ID instruction (NOP_INSTR when validOut=0)
//   nextPcOut         IF/ID fetch address + 2
//   validOut          IF/ID holds a real instruction
//   halted            fetch stopped after delivering a HALT
//   err               sticky error flag (memory error or misaligned fetch)
//
// Optional feature, macro FETCH_PERF_EN:
//   adds fetchCount (instructions loaded into IF/ID) and stallCycles
//   (cycles with stall=1 and validOut=1), both 16-bit wrapping counters.

module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirectPc,
    output logic        imemEn,
    output logic [15:0] imemAddr,
    input  logic [15:0] imemData,
    input  logic        imemDone,
    input  logic        imemErr,
    output logic [15:0] instrOut,
    output logic [15:0] nextPcOut,
    output logic        validOut,
    output logic        halted,
`ifdef FETCH_PERF_EN
    output logic [15:0] fetchCount,
    output logic [15:0] stallCycles,
`endif
    output logic        err
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_WAIT   = 2'd1,
        S_HOLD   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] pc_inc;
    logic [15:0] buf_data;
    logic        buf_full;
    logic        drop;
    logic        en_q;
    logic [15:0] instr_q;
    logic [15:0] next_pc_q;
    logic        valid_q;
    logic        halted_q;
    logic        err_q;

    logic        take_mem;
    logic        take_buf;
    logic        deliver;
    logic [15:0] new_instr;
    logic        new_is_halt;

`ifdef FETCH_PERF_EN
    logic [15:0] fetch_count_q;
    logic [15:0] stall_cycles_q;
`endif

    assign pc_inc = pc + 16'd2;   // wraps modulo 2^16

    // A response goes straight into IF/ID when decode can take it (or IF/ID
    // is empty anyway); otherwise it parks in the one-entry buffer.
    assign take_mem    = (state == S_WAIT) && imemDone && !drop && (!stall || !valid_q);
    assign take_buf    = (state == S_HOLD) && buf_full && !stall;
    assign deliver     = take_mem || take_buf;
    assign new_instr   = take_buf ? buf_data : imemData;
    assign new_is_halt = (new_instr[15:11] == 5'b00000);

    // en_q is the registered request strobe. It is raised on every entry to
    // FETCH so a request leaves in the first FETCH cycle; the only FETCH
    // cycle without it is the one right after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            pc        <= RESET_PC;
            buf_data  <= 16'h0000;
            buf_full  <= 1'b0;
            drop      <= 1'b0;
            en_q      <= 1'b0;
            instr_q   <= NOP_INSTR;
            next_pc_q <= 16'h0000;
            valid_q   <= 1'b0;
            halted_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            // Error sources are independent of redirect/stall.
            if (state == S_FETCH && en_q && pc[0])
                err_q <= 1'b1;
            if (state == S_WAIT && imemDone && imemErr && !drop)
                err_q <= 1'b1;

            if (redirect) begin
                valid_q  <= 1'b0;
                instr_q  <= NOP_INSTR;
                buf_full <= 1'b0;
                pc       <= redirectPc;
                halted_q <= 1'b0;
                if (state == S_WAIT && !imemDone) begin
                    // Request still in flight: swallow its response first.
                    drop  <= 1'b1;
                    en_q  <= 1'b0;
                    state <= S_WAIT;
                end else begin
                    drop  <= 1'b0;
                    en_q  <= 1'b1;
                    state <= S_FETCH;
                end
            end else begin
                // IF/ID register: load, hold under stall, or drain to NOP.
                if (deliver) begin
                    valid_q   <= 1'b1;
                    instr_q   <= new_instr;
                    next_pc_q <= pc_inc;
                end else if (!stall) begin
                    valid_q <= 1'b0;
                    instr_q <= NOP_INSTR;
                end

                unique case (state)
                    S_FETCH: begin
                        if (en_q) begin
                            en_q  <= 1'b0;
                            state <= S_WAIT;
                        end else begin
                            en_q <= 1'b1;
                        end
                    end
                    S_WAIT: begin
                        if (imemDone) begin
                            if (drop) begin
                                drop  <= 1'b0;
                                en_q  <= 1'b1;
                                state <= S_FETCH;
                            end else if (!take_mem) begin
                                buf_data <= imemData;
                                buf_full <= 1'b1;
                                state    <= S_HOLD;
                            end
                        end
                    end
                    S_HOLD: begin
                        // Leaves through the deliver path below.
                    end
                    S_HALTED: begin
                        // Only a redirect or reset restarts fetching.
                    end
                endcase

                // Common tail for any instruction entering IF/ID; overrides
                // the state set above.
                if (deliver) begin
                    pc       <= pc_inc;
                    buf_full <= 1'b0;
                    if (new_is_halt) begin
                        halted_q <= 1'b1;
                        en_q     <= 1'b0;
                        state    <= S_HALTED;
                    end else begin
                        en_q  <= 1'b1;
                        state <= S_FETCH;
                    end
                end
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count_q  <= 16'h0000;
            stall_cycles_q <= 16'h0000;
        end else begin
            if (deliver && !redirect)
                fetch_count_q <= fetch_count_q + 16'd1;
            if (stall && valid_q)
                stall_cycles_q <= stall_cycles_q + 16'd1;
        end
    end

    assign fetchCount  = fetch_count_q;
    assign stallCycles = stall_cycles_q;
`endif

    assign imemEn    = (state == S_FETCH) && en_q;
    assign imemAddr  = pc;
    assign instrOut  = instr_q;
    assign nextPcOut = next_pc_q;
    assign validOut  = valid_q;
    assign halted    = halted_q;
    assign err       = err_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage WISC pipeline. It owns the PC and issues requests to the instruction memory over a request/done handshake.
- Presents `instrOut`/`nextPcOut` to the decode stage through an internal IF/ID output register.
- Handles back-pressure stalls from the hazard unit, redirects from branch/jump resolution, and halt detection.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0800, encoding driven on `instrOut` whenever `validOut`=0.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  decode cannot accept; hold the IF/ID register.
- redirect  input  1  branch/jump taken; flush and refetch from `redirectPc`.
- redirectPc  input  16  redirect target.
- imemEn  output  1  one-cycle instruction memory request strobe.
- imemAddr  output  16  request address, valid while `imemEn`=1.
- imemData  input  16  returned instruction, valid when `imemDone`=1.
- imemDone  input  1  memory response strobe, at least 1 cycle after the request.
- imemErr  input  1  memory error, sampled with `imemDone`.
- instrOut  output  16  IF/ID instruction; NOP_INSTR when invalid.
- nextPcOut  output  16  IF/ID fetch address + 2.
- validOut  output  1  IF/ID holds a real instruction.
- halted  output  1  fetch stopped after delivering a HALT.
- err  output  1  sticky error flag.

Behaviour:
- Reset (synchronous, `rst`=1 at a clk edge), applied in any state:
  - pc=RESET_PC, state=FETCH, validOut=0, instrOut=NOP_INSTR, nextPcOut=0.
  - halted=0, err=0, imemEn=0, buffer empty, drop flag clear.
  - Any in-flight memory response is ignored.
- States:
  - FETCH: imemEn=1, imemAddr=pc; next state WAIT.
  - WAIT: imemEn=0; waiting for `imemDone`.
  - HOLD: response captured in a one-entry buffer; waiting for `stall` to drop.
  - HALTED: no requests issued.
- WAIT with imemDone=1 and no redirect:
  - If stall=0, or validOut=0: load the IF/ID register with instrOut=imemData, nextPcOut=pc+2, validOut=1; set pc=pc+2; go to FETCH.
  - If stall=1 and validOut=1: write imemData into the buffer; go to HOLD.
- HOLD with stall=0: move the buffer into the IF/ID register; set pc=pc+2; go to FETCH.
- IF/ID register with stall=1: holds its value. With stall=0 and nothing new to deliver: validOut goes to 0.
- Throughput: at best one instruction every 2 cycles with single-cycle memory. Latency from `imemEn` to `validOut` is the memory latency + 1 cycle.
- Halt:
  - An instruction with opcode [15:11]=5'b00000 that enters IF/ID sets halted=1 and moves the state to HALTED.
  - The HALT itself stays visible in IF/ID until consumed.
- Redirect (has priority over every other event in the same cycle):
  - validOut=0, buffer cleared, pc=redirectPc, halted=0.
  - If a request is outstanding (WAIT with imemDone=0): set the drop flag, stay in WAIT, and discard the next imemDone. When the drop flag clears, go to FETCH.
  - Otherwise (including imemDone=1 in the same cycle): discard the data and go to FETCH next cycle.
  - Redirect with stall=1: the flush still wins.
- err is sticky until rst. It is set by:
  - imemErr=1 together with imemDone=1, for a response that is not being dropped;
  - a FETCH with pc[0]=1 (misaligned); the request is still issued.
- Arithmetic: pc+2 is modulo 2^16 (16'hFFFE+2 wraps to 0).

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: adds outputs fetchCount[15:0] and stallCycles[15:0], both reset to 0 and wrapping at 2^16.
  - fetchCount increments on each instruction loaded into IF/ID.
  - stallCycles increments on every cycle with stall=1 and validOut=1.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, then single-cycle memory returning 16'h4000,16'h4020,...: imemAddr sequence 0,2,4; validOut pulses with nextPcOut 2,4,6; instrOut is NOP_INSTR between valid cycles.
- Stall held for 3 cycles while a response arrives: IF/ID is unchanged, state is HOLD, no imemEn is issued; after stall drops, the buffered instruction appears on the next edge.
- Redirect to 16'h0100 while a 3-cycle-latency request is outstanding: the late response is dropped, validOut=0, and the next imemAddr is 16'h0100.
- Memory returns 16'h0000 (HALT): halted=1 and imemEn stays 0 for 10 cycles; a redirect to 16'h0040 then clears halted and fetches from 16'h0040.
- imemErr=1 with imemDone=1, and separately a redirect to 16'h0003: err=1 and stays 1 until rst; rst clears err and returns pc to 0.
- pc=16'hFFFE: nextPcOut=16'h0000 and the next imemAddr is 16'h0000.
